rgb2luma: RTL and testbench
===========================

RGB2LUMA -- requirements
Module: rgb2luma

Interface
REQ-001 SHALL have parameter WIDTH_P, default 8, meaning per-channel and output pixel width in bits.
REQ-002 SHALL have parameter USER_W_P, default 1, meaning width of sideband user field carried with each pixel.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port valid_i  input  1  upstream beat valid.
REQ-006 SHALL have port ready_o  output  1  block accepts beat this cycle.
REQ-007 SHALL have ports red_i, green_i, blue_i  input  WIDTH_P each  pixel channels.
REQ-008 SHALL have port mode_i  input  2  weight set for this beat: 0 BT.601, 1 BT.709, 2 equal, 3 green passthrough.
REQ-009 SHALL have port user_i  input  USER_W_P  sideband (e.g. end-of-line), returned unchanged.
REQ-010 SHALL have port valid_o  output  1  output beat valid.
REQ-011 SHALL have port ready_i  input  1  downstream accepts output beat.
REQ-012 SHALL have ports gray_o  output  WIDTH_P  luma, and user_o  output  USER_W_P  sideband.

Function
REQ-013 SHALL transfer an input beat iff valid_i && ready_o, and an output beat iff valid_o && ready_i.
REQ-014 SHALL use 8-bit fractional weights (R,G,B): mode0 (77,150,29), mode1 (54,183,19), mode2 (85,86,85), all summing to 256.
REQ-015 SHALL compute gray = (wR*R + wG*G + wB*B + 128) >> 8, products WIDTH_P+8 bits, sum WIDTH_P+10 bits, no intermediate truncation.
REQ-016 SHALL saturate gray_o to 2^WIDTH_P-1 if the shifted sum exceeds it.
REQ-017 SHALL in mode3 output green_i unchanged, with the same latency as other modes.
REQ-018 SHALL be a 2-stage pipeline: stage 1 registers three products plus mode/user; stage 2 registers rounded, saturated sum plus user.
REQ-019 SHALL have latency exactly 2 cycles from input transfer to valid_o when ready_i is held high.
REQ-020 SHALL sustain one beat per cycle with ready_i high.
REQ-021 SHALL latch mode_i and user_i per beat; a mode change between consecutive beats SHALL affect only the later beat.
REQ-022 SHALL per stage advance when the stage is empty or its downstream transfers; ready_o = stage-1 empty or stage-1 advancing.
REQ-023 SHALL hold gray_o, user_o and valid_o stable while valid_o && !ready_i.
REQ-024 SHALL never drop, duplicate or reorder beats under any ready_i pattern; at most 2 beats in flight.
REQ-025 SHALL, on simultaneous full pipe, ready_i high and valid_i high, accept the new beat and emit the oldest in the same cycle.
REQ-026 SHALL not depend combinationally on valid_i for valid_o or gray_o.

Reset
REQ-027 SHALL on rstn_i low clear both stage valid bits immediately: valid_o=0, gray_o=0, user_o=0.
REQ-028 SHALL drive ready_o=1 while reset is deasserted and the pipe is empty.
REQ-029 SHALL discard in-flight beats on reset mid-operation; first output after release is the first beat accepted after release.

Structure
REQ-030 SHALL place the mode enum (MODE_601, MODE_709, MODE_EQ, MODE_G) and the weight table constants in package rgb2luma_pkg.
REQ-031 SHALL implement each pipeline register with valid/ready as one sub-module pipe_stage, instantiated twice.

Verification (WIDTH_P=8, ready_i=1 unless stated)
REQ-032 SHALL check: reset, valid_i=0 for 4 cycles -> valid_o=0 each cycle, ready_o=1.
REQ-033 SHALL check: mode0 (255,255,255)->255; mode0 (255,0,0)->77; mode0 (0,0,255)->29; each valid_o exactly 2 cycles after accept.
REQ-034 SHALL check: mode1 (0,255,0)->182; mode2 (30,60,90)->60; mode3 (30,60,90)->60; back-to-back beats with alternating modes -> each result uses its own mode.
REQ-035 SHALL check: 3 beats offered, ready_i low 5 cycles -> 2 accepted, ready_o=0, gray_o stable; on ready_i high all 3 emerge in order with matching user_o.
REQ-036 SHALL check: rstn_i pulsed low with 2 beats in flight -> valid_o=0 immediately, no stale beat after release.
REQ-037 SHALL check: 1000 random beats, random modes, random ready_i -> every output equals the REQ-015 integer model exactly, count in equals count out.

Source files
------------

// File: rtl/rgb2luma_pkg.sv
// Shared types and constants for the RGB-to-luma pipeline.
// Weight sets are 8-bit fractions of 256, widened to 9 bits so green passthrough can use unity.
package rgb2luma_pkg;

  typedef enum logic [1:0] {
    MODE_601 = 2'd0,
    MODE_709 = 2'd1,
    MODE_EQ  = 2'd2,
    MODE_G   = 2'd3
  } mode_e;

  localparam int WGT_W = 9;
  typedef logic [WGT_W-1:0] wgt_t;

  typedef struct packed {
    wgt_t r;
    wgt_t g;
    wgt_t b;
  } wgt_set_t;

  localparam wgt_set_t WGT_601 = '{r: 9'd77, g: 9'd150, b: 9'd29};
  localparam wgt_set_t WGT_709 = '{r: 9'd54, g: 9'd183, b: 9'd19};
  localparam wgt_set_t WGT_EQ  = '{r: 9'd85, g: 9'd86,  b: 9'd85};
  // Unity green weight makes the rounded sum reproduce green_i exactly.
  localparam wgt_set_t WGT_G   = '{r: 9'd0,  g: 9'd256, b: 9'd0};

  function automatic wgt_set_t mode_weights(input mode_e m);
    wgt_set_t w;
    case (m)
      MODE_601: w = WGT_601;
      MODE_709: w = WGT_709;
      MODE_EQ:  w = WGT_EQ;
      default:  w = WGT_G;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rgb2luma_if.sv
// Valid/ready beat channel with a parameterised payload, used between pipeline stages.
interface rgb2luma_if #(
  parameter int DATA_W = 8
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/rgb2luma_pipe_stage.sv
// One valid/ready pipeline register: loads when empty or when its own beat leaves downstream.
module pipe_stage #(
  parameter int DATA_W = 8
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  rgb2luma_if.slave    up_if,
  rgb2luma_if.master   dn_if
);
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              advance;

  assign advance     = !valid_q || dn_if.ready;
  assign up_if.ready = advance;
  assign dn_if.valid = valid_q;
  assign dn_if.data  = data_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (advance) begin
      valid_q <= up_if.valid;
      if (up_if.valid) begin
        data_q <= up_if.data;
      end
    end
  end
endmodule

// File: rtl/rgb2luma.sv
// Two-stage RGB-to-luma converter: stage 1 holds weighted products, stage 2 the rounded,
// saturated luma. Mode and sideband travel with each beat.
module rgb2luma
  import rgb2luma_pkg::*;
#(
  parameter int WIDTH_P  = 8,
  parameter int USER_W_P = 1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [WIDTH_P-1:0]  red_i,
  input  logic [WIDTH_P-1:0]  green_i,
  input  logic [WIDTH_P-1:0]  blue_i,
  input  logic [1:0]          mode_i,
  input  logic [USER_W_P-1:0] user_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [WIDTH_P-1:0]  gray_o,
  output logic [USER_W_P-1:0] user_o
);
  localparam int PROD_W = WIDTH_P + 8;
  localparam int SUM_W  = WIDTH_P + 10;
  localparam int S1_W   = 3 * PROD_W + 2 + USER_W_P;
  localparam int S2_W   = WIDTH_P + USER_W_P;
  localparam logic [SUM_W-1:0] GRAY_MAX = SUM_W'((1 << WIDTH_P) - 1);

  rgb2luma_if #(.DATA_W(S1_W)) s1_in_if  ();
  rgb2luma_if #(.DATA_W(S1_W)) s1_out_if ();
  rgb2luma_if #(.DATA_W(S2_W)) s2_in_if  ();
  rgb2luma_if #(.DATA_W(S2_W)) s2_out_if ();

  wgt_set_t                  wgt;
  wgt_t [2:0]                wgt_vec;
  logic [2:0][WIDTH_P-1:0]   chan;
  logic [2:0][PROD_W-1:0]    prod_d;

  assign wgt     = mode_weights(mode_e'(mode_i));
  assign wgt_vec = wgt;
  assign chan    = {red_i, green_i, blue_i};

  // Largest product is (2^WIDTH_P-1)*256, so PROD_W bits never truncate.
  for (genvar gi = 0; gi < 3; gi++) begin : g_mul
    assign prod_d[gi] = PROD_W'(chan[gi]) * PROD_W'(wgt_vec[gi]);
  end

  assign s1_in_if.valid = valid_i;
  assign s1_in_if.data  = {prod_d, mode_i, user_i};
  assign ready_o        = s1_in_if.ready;

  pipe_stage #(.DATA_W(S1_W)) u_stage1 (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .up_if  (s1_in_if),
    .dn_if  (s1_out_if)
  );

  logic [2:0][PROD_W-1:0]  prod_q;
  logic [1:0]              mode_q;
  logic [USER_W_P-1:0]     user_q;
  logic [SUM_W-1:0]        sum_d;
  logic [SUM_W-1:0]        shifted_d;
  logic [WIDTH_P-1:0]      gray_d;

  assign {prod_q, mode_q, user_q} = s1_out_if.data;
  assign sum_d     = SUM_W'(prod_q[0]) + SUM_W'(prod_q[1]) + SUM_W'(prod_q[2]) + SUM_W'(128);
  assign shifted_d = sum_d >> 8;

  always_comb begin
    gray_d = shifted_d[WIDTH_P-1:0];
    if (mode_e'(mode_q) == MODE_G) begin
      gray_d = prod_q[1][PROD_W-1:8];
    end else if (shifted_d > GRAY_MAX) begin
      gray_d = '1;
    end
  end

  assign s2_in_if.valid  = s1_out_if.valid;
  assign s2_in_if.data   = {gray_d, user_q};
  assign s1_out_if.ready = s2_in_if.ready;

  pipe_stage #(.DATA_W(S2_W)) u_stage2 (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .up_if  (s2_in_if),
    .dn_if  (s2_out_if)
  );

  assign s2_out_if.ready  = ready_i;
  assign valid_o          = s2_out_if.valid;
  assign {gray_o, user_o} = s2_out_if.data;
endmodule

// File: tb/tb_rgb2luma.sv
// Directed and randomised checks of rgb2luma against an arithmetic luma model with an
// in-order expectation queue.
module tb_rgb2luma;
  localparam int WIDTH = 8;
  localparam int UW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstn_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] red_i, green_i, blue_i;
  logic [1:0]       mode_i;
  logic [UW-1:0]    user_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] gray_o;
  logic [UW-1:0]    user_o;

  rgb2luma_if #(.DATA_W(WIDTH)) dn_bus ();
  assign dn_bus.valid = valid_o;
  assign dn_bus.data  = gray_o;
  assign ready_i      = dn_bus.ready;

  rgb2luma #(.WIDTH_P(WIDTH), .USER_W_P(UW)) dut (
    .clk_i   (clk),
    .rstn_i  (rstn_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .red_i   (red_i),
    .green_i (green_i),
    .blue_i  (blue_i),
    .mode_i  (mode_i),
    .user_i  (user_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .gray_o  (gray_o),
    .user_o  (user_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_in = 0;
  int n_out = 0;
  int pend_exp = -1;
  bit chk_lat = 1'b0;
  bit last_acc = 1'b0;
  bit stall_prev = 1'b0;
  logic [WIDTH-1:0] held_gray;
  logic [UW-1:0]    held_user;
  int exp_gray_q[$];
  int exp_user_q[$];
  int acc_cyc_q[$];

  function automatic int ref_luma(input int r, input int g, input int b, input int m);
    int wr = 0, wg = 0, wb = 0, s;
    case (m)
      0: begin wr = 77; wg = 150; wb = 29; end
      1: begin wr = 54; wg = 183; wb = 19; end
      2: begin wr = 85; wg = 86;  wb = 85; end
      default: return g;
    endcase
    s = (wr * r + wg * g + wb * b + 128) / 256;
    return (s > 255) ? 255 : s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs at the falling edge, where every handshake about to be taken is already settled.
  task automatic monitor();
    int g, u, a;
    last_acc = 1'b0;
    if (stall_prev) chk("hold_valid", valid_o, 1);
    if (valid_o === 1'b1 && ready_i === 1'b1) begin
      n_out++;
      if (exp_gray_q.size() == 0) begin
        chk("spurious_out", exp_gray_q.size(), 1);
      end else begin
        g = exp_gray_q.pop_front();
        u = exp_user_q.pop_front();
        a = acc_cyc_q.pop_front();
        chk("gray", gray_o, g);
        chk("user", user_o, u);
        if (chk_lat) chk("latency", cyc - a, 2);
      end
    end
    if (valid_o === 1'b1 && ready_i === 1'b0) begin
      if (stall_prev) begin
        chk("hold_gray", gray_o, held_gray);
        chk("hold_user", user_o, held_user);
      end
      held_gray  = gray_o;
      held_user  = user_o;
      stall_prev = 1'b1;
    end else begin
      stall_prev = 1'b0;
    end
    if (valid_i === 1'b1 && ready_o === 1'b1) begin
      exp_gray_q.push_back(pend_exp >= 0 ? pend_exp
                                         : ref_luma(red_i, green_i, blue_i, mode_i));
      exp_user_q.push_back(user_i);
      acc_cyc_q.push_back(cyc);
      n_in++;
      last_acc = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive(input int r, input int g, input int b, input int m, input int u);
    red_i   = WIDTH'(r);
    green_i = WIDTH'(g);
    blue_i  = WIDTH'(b);
    mode_i  = 2'(m);
    user_i  = UW'(u);
  endtask

  task automatic send_dir(input int r, input int g, input int b, input int m, input int u,
                          input int exp);
    drive(r, g, b, m, u);
    pend_exp = exp;
    valid_i  = 1'b1;
    tick();
    valid_i  = 1'b0;
    pend_exp = -1;
  endtask

  task automatic flush(input string tag);
    repeat (4) tick();
    chk(tag, exp_gray_q.size(), 0);
  endtask

  int k;
  int base;
  int guard;
  int rand_acc;
  int sr[3], sg[3], sb[3], sm[3];

  initial begin
    rstn_i = 1'b0;
    valid_i = 1'b0;
    drive(0, 0, 0, 0, 0);
    dn_bus.ready = 1'b1;

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_gray_o", gray_o, 0);
    chk("rst_user_o", user_o, 0);
    rstn_i = 1'b1;
    repeat (4) begin
      tick();
      chk("idle_valid_o", valid_o, 0);
      chk("idle_ready_o", ready_o, 1);
    end

    // Directed values with latency tracking
    chk_lat = 1'b1;
    send_dir(255, 255, 255, 0, 1, 255);
    flush("drain_601_white");
    send_dir(255, 0, 0, 0, 2, 77);
    flush("drain_601_red");
    send_dir(0, 0, 255, 0, 3, 29);
    flush("drain_601_blue");
    send_dir(0, 255, 0, 1, 4, 182);
    send_dir(30, 60, 90, 2, 5, 60);
    send_dir(30, 60, 90, 3, 6, 60);
    flush("drain_modes");

    // Back-to-back beats with rotating modes
    valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), i % 4, i);
      tick();
    end
    valid_i = 1'b0;
    flush("drain_alternate");

    // Downstream stall with three beats offered
    chk_lat = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sr[i] = $urandom_range(0, 255);
      sg[i] = $urandom_range(0, 255);
      sb[i] = $urandom_range(0, 255);
      sm[i] = $urandom_range(0, 3);
    end
    dn_bus.ready = 1'b0;
    k = 0;
    base = n_in;
    for (int c = 0; c < 5; c++) begin
      valid_i = (k < 3);
      if (k < 3) drive(sr[k], sg[k], sb[k], sm[k], 8 + k);
      tick();
      if (last_acc) k++;
    end
    chk("stall_accepted", n_in - base, 2);
    chk("stall_ready_o", ready_o, 0);
    dn_bus.ready = 1'b1;
    guard = 0;
    while (k < 3 && guard < 10) begin
      valid_i = 1'b1;
      drive(sr[k], sg[k], sb[k], sm[k], 8 + k);
      tick();
      if (last_acc) k++;
      guard++;
    end
    valid_i = 1'b0;
    chk("stall_all_accepted", k, 3);
    flush("drain_stall");

    // Reset with two beats in flight
    chk_lat = 1'b1;
    valid_i = 1'b1;
    drive(10, 20, 30, 0, 1);
    tick();
    drive(40, 50, 60, 1, 2);
    tick();
    valid_i = 1'b0;
    chk("pre_reset_valid_o", valid_o, 1);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("midrst_valid_o", valid_o, 0);
    chk("midrst_gray_o", gray_o, 0);
    chk("midrst_user_o", user_o, 0);
    n_in = n_in - exp_gray_q.size();
    exp_gray_q.delete();
    exp_user_q.delete();
    acc_cyc_q.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    rstn_i = 1'b1;
    repeat (4) begin
      tick();
      chk("postrst_valid_o", valid_o, 0);
    end
    chk("postrst_ready_o", ready_o, 1);
    send_dir(255, 0, 0, 0, 7, 77);
    flush("drain_postrst");

    // Random traffic with random backpressure
    chk_lat = 1'b0;
    rand_acc = 0;
    guard = 0;
    while (rand_acc < 1000 && guard < 20000) begin
      valid_i = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 3), $urandom_range(0, 15));
      dn_bus.ready = ($urandom_range(0, 9) < 7);
      tick();
      if (last_acc) rand_acc++;
      guard++;
    end
    valid_i = 1'b0;
    dn_bus.ready = 1'b1;
    chk("rand_accepted", rand_acc, 1000);
    flush("drain_random");
    chk("count_in_out", n_out, n_in);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
